// File: rtl/exp6_detector_jogada_pkg.sv
// exp6_detector_jogada_pkg: debug state codes and default debounce length shared across the game
package exp6_detector_jogada_pkg;
   typedef enum logic [3:0] {
      ESPERA_SOLTO = 4'b0000,
      LIVRE        = 4'b0001,
      PULSO        = 4'b0010
   } estado_t;
   localparam logic [3:0] EST_INVALIDO = 4'b1111;
   localparam int DEBOUNCE_CICLOS_PADRAO = 50000;
endpackage

// File: rtl/exp6_debouncer.sv
// exp6_debouncer: two-flop synchronizer plus whole-vector stability filter
module exp6_debouncer
   import exp6_detector_jogada_pkg::*;
#(
   parameter int W      = 4,
   parameter int CICLOS = DEBOUNCE_CICLOS_PADRAO
) (
   input  logic         clock,
   input  logic         reset,
   input  logic [W-1:0] botoes_i,
   output logic [W-1:0] filtrado_o
);
   localparam int CW = $clog2(CICLOS);
   localparam logic [CW-1:0] CNT_MAX = CW'(CICLOS - 1);
   logic [W-1:0]  sinc1_q, sinc2_q, cand_q, cand_d, filt_q, filt_d;
   logic [CW-1:0] cnt_q, cnt_d;
   // any change of the synchronized vector restarts the count; a saturated count publishes the candidate
   always_comb begin
      cand_d = sinc2_q;
      cnt_d  = (sinc2_q != cand_q) ? '0 : (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
      filt_d = (sinc2_q == cand_q && cnt_q == CNT_MAX) ? cand_q : filt_q;
   end
   // synchronizer and filter state
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sinc1_q <= '0;
         sinc2_q <= '0;
         cand_q  <= '0;
         cnt_q   <= '0;
         filt_q  <= '0;
      end else begin
         sinc1_q <= botoes_i;
         sinc2_q <= sinc1_q;
         cand_q  <= cand_d;
         cnt_q   <= cnt_d;
         filt_q  <= filt_d;
      end
   end
   assign filtrado_o = filt_q;
endmodule

// File: rtl/exp6_detector_jogada.sv
// exp6_detector_jogada: turns debounced one-hot presses into a single-cycle jogada pulse
module exp6_detector_jogada
   import exp6_detector_jogada_pkg::*;
#(
   parameter int N_BOTOES        = 4,
   parameter int DEBOUNCE_CICLOS = DEBOUNCE_CICLOS_PADRAO
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [N_BOTOES-1:0] botoes,
   input  logic                habilita,
   output logic                jogada,
   output logic [N_BOTOES-1:0] jogada_valor,
   output logic                db_invalida,
   output logic [N_BOTOES-1:0] db_botoes_filtrados,
   output logic [3:0]          db_estado
);
   estado_t             state_q;
   logic                jogada_q, invalida_q;
   logic [N_BOTOES-1:0] valor_q, filt;
   logic                um_quente;
   exp6_debouncer #(
      .W      (N_BOTOES),
      .CICLOS (DEBOUNCE_CICLOS)
   ) u_debouncer (
      .clock      (clock),
      .reset      (reset),
      .botoes_i   (botoes),
      .filtrado_o (filt)
   );
   assign um_quente = (filt != '0) && ((filt & (filt - 1'b1)) == '0);
   // press FSM: a key must be seen released before the next press can be accepted
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= ESPERA_SOLTO;
         jogada_q   <= 1'b0;
         valor_q    <= '0;
         invalida_q <= 1'b0;
      end else begin
         jogada_q <= 1'b0;
         case (state_q)
            ESPERA_SOLTO: if (filt == '0) state_q <= LIVRE;
            LIVRE: if (filt != '0) begin
               if (um_quente && habilita) begin
                  state_q    <= PULSO;
                  jogada_q   <= 1'b1;
                  valor_q    <= filt;
                  invalida_q <= 1'b0;
               end else begin
                  state_q <= ESPERA_SOLTO;
                  if (!um_quente) invalida_q <= 1'b1;
               end
            end
            PULSO:   state_q <= ESPERA_SOLTO;
            default: state_q <= ESPERA_SOLTO;
         endcase
      end
   end
   assign jogada              = jogada_q;
   assign jogada_valor        = valor_q;
   assign db_invalida         = invalida_q;
   assign db_botoes_filtrados = filt;
   assign db_estado           = (state_q inside {ESPERA_SOLTO, LIVRE, PULSO}) ? state_q : EST_INVALIDO;
endmodule

// File: tb/tb_exp6_detector_jogada.sv
// tb_exp6_detector_jogada: scoreboard bench with a windowed reference model and directed plus random presses
module tb_exp6_detector_jogada;
   localparam int N = 4;
   localparam int D = 4;
   logic         clock = 1'b0;
   logic         reset = 1'b1;
   logic [N-1:0] botoes = '0;
   logic         habilita = 1'b0;
   logic         jogada, db_invalida;
   logic [N-1:0] jogada_valor, db_botoes_filtrados;
   logic [3:0]   db_estado;
   typedef struct packed {
      logic       jog;
      logic [3:0] val;
      logic       inv;
      logic [3:0] filt;
      logic [3:0] est;
   } saida_t;
   saida_t exp_q[$];
   int n_checks = 0;
   int n_fail = 0;
   int n_pulsos = 0;
   exp6_detector_jogada #(
      .N_BOTOES        (N),
      .DEBOUNCE_CICLOS (D)
   ) dut (
      .clock               (clock),
      .reset               (reset),
      .botoes              (botoes),
      .habilita            (habilita),
      .jogada              (jogada),
      .jogada_valor        (jogada_valor),
      .db_invalida         (db_invalida),
      .db_botoes_filtrados (db_botoes_filtrados),
      .db_estado           (db_estado)
   );
   always #5 clock = ~clock;
   task automatic check(input string nome, input logic [3:0] act, input logic [3:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %b, expected %b at %0t", nome, act, req, $time);
      end
   endtask
   // reference model: a value is accepted once the synchronized stream has held it for D+1 samples;
   // a press is reported only if the stream went to zero since the last accepted non-zero value
   initial begin
      logic [3:0] raw[$];
      logic [3:0] m_filt, m_val;
      logic       m_armed, m_pulse, m_inv, estavel;
      saida_t     s;
      forever begin
         @(posedge clock or posedge reset);
         if (reset) begin
            raw = {};
            for (int i = 0; i < D + 2; i++) raw.push_back(4'b0);
            m_filt = '0; m_val = '0; m_armed = 0; m_pulse = 0; m_inv = 0;
            exp_q.delete();
         end else begin
            if (m_pulse) m_pulse = 0;
            else if (!m_armed) m_armed = (m_filt == 0);
            else if (m_filt != 0) begin
               m_armed = 0;
               if ($countones(m_filt) == 1 && habilita) begin
                  m_pulse = 1; m_val = m_filt; m_inv = 0;
               end else if ($countones(m_filt) > 1) m_inv = 1;
            end
            estavel = 1;
            for (int i = 0; i < D; i++) if (raw[i] != raw[D]) estavel = 0;
            if (estavel) m_filt = raw[D];
            raw.push_back(botoes);
            void'(raw.pop_front());
            s.jog = m_pulse; s.val = m_val; s.inv = m_inv; s.filt = m_filt;
            s.est = m_pulse ? 4'd2 : m_armed ? 4'd1 : 4'd0;
            exp_q.push_back(s);
         end
      end
   end
   // monitor: compares every presented output cycle against the next scoreboard entry
   initial begin
      saida_t cur;
      cur = '0;
      forever begin
         @(negedge clock);
         if (reset) cur = '0;
         else if (exp_q.size() > 0) cur = exp_q.pop_front();
         check("jogada", {3'b0, jogada}, {3'b0, cur.jog});
         check("jogada_valor", jogada_valor, cur.val);
         check("db_invalida", {3'b0, db_invalida}, {3'b0, cur.inv});
         check("db_botoes_filtrados", db_botoes_filtrados, cur.filt);
         check("db_estado", db_estado, cur.est);
         if (jogada) n_pulsos++;
      end
   end
   task automatic tick(input int n);
      repeat (n) @(negedge clock);
   endtask
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end
   initial begin
      int p;
      logic [3:0] v;
      tick(3);
      check("reset_jogada", {3'b0, jogada}, 4'b0);
      check("reset_estado", db_estado, 4'b0000);
      check("reset_filtrado", db_botoes_filtrados, 4'b0);
      botoes = 4'b0100; habilita = 1; reset = 0;
      for (int e = 1; e <= 10; e++) begin
         @(negedge clock);
         check($sformatf("latencia_e%0d", e), {3'b0, jogada}, {3'b0, e == 8});
      end
      check("limpo_valor", jogada_valor, 4'b0100);
      botoes = 0; tick(12);
      check("limpo_livre", db_estado, 4'b0001);
      p = n_pulsos;
      for (int i = 0; i < 5; i++) begin
         botoes = (i % 2 == 0) ? 4'b0001 : 4'b0000;
         tick(2);
      end
      check("bounce_sem_pulso", 4'(n_pulsos - p), 4'd0);
      tick(20);
      check("bounce_um_pulso", 4'(n_pulsos - p), 4'd1);
      check("bounce_valor", jogada_valor, 4'b0001);
      botoes = 0; tick(12);
      p = n_pulsos; botoes = 4'b1000; tick(200);
      check("segurado_um_pulso", 4'(n_pulsos - p), 4'd1);
      botoes = 0; tick(12);
      p = n_pulsos; botoes = 4'b0010; tick(12);
      check("segundo_pulso", 4'(n_pulsos - p), 4'd1);
      check("segundo_valor", jogada_valor, 4'b0010);
      botoes = 0; tick(12);
      p = n_pulsos; botoes = 4'b0011; tick(15);
      check("multi_sem_pulso", 4'(n_pulsos - p), 4'd0);
      check("multi_invalida", {3'b0, db_invalida}, 4'd1);
      check("multi_valor", jogada_valor, 4'b0010);
      botoes = 0; tick(12);
      p = n_pulsos; botoes = 4'b0100; tick(12);
      check("apos_multi_pulso", 4'(n_pulsos - p), 4'd1);
      check("apos_multi_invalida", {3'b0, db_invalida}, 4'd0);
      botoes = 0; tick(12);
      p = n_pulsos; habilita = 0; botoes = 4'b0001; tick(15);
      check("desab_sem_pulso", 4'(n_pulsos - p), 4'd0);
      habilita = 1; tick(15);
      check("hab_tardio_sem_pulso", 4'(n_pulsos - p), 4'd0);
      botoes = 0; tick(12); botoes = 4'b0001; tick(12);
      check("hab_repress_pulso", 4'(n_pulsos - p), 4'd1);
      botoes = 0; tick(12);
      botoes = 4'b0100;
      for (int i = 0; i < 30 && !jogada; i++) @(negedge clock);
      check("espera_pulso", {3'b0, jogada}, 4'd1);
      #1 reset = 1;
      #1;
      check("rst_jogada", {3'b0, jogada}, 4'd0);
      check("rst_valor", jogada_valor, 4'd0);
      check("rst_estado", db_estado, 4'd0);
      check("rst_filtrado", db_botoes_filtrados, 4'd0);
      p = n_pulsos;
      tick(3); habilita = 0; tick(1); reset = 0; tick(15);
      check("rst_segurado_sem_pulso", 4'(n_pulsos - p), 4'd0);
      habilita = 1; tick(15);
      check("rst_hab_sem_pulso", 4'(n_pulsos - p), 4'd0);
      botoes = 0; tick(12); botoes = 4'b0100; tick(12);
      check("rst_repress_pulso", 4'(n_pulsos - p), 4'd1);
      for (int k = 0; k < 80; k++) begin
         case ($urandom_range(0, 3))
            0: v = 4'b0;
            1, 2: v = 4'b1 << $urandom_range(0, 3);
            default: begin
               v = 4'($urandom_range(0, 15));
               while ($countones(v) < 2) v = 4'($urandom_range(0, 15));
            end
         endcase
         botoes = v;
         habilita = ($urandom_range(0, 3) != 0);
         tick($urandom_range(1, 12));
      end
      botoes = 0; tick(12);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
